lock_ctrl: RTL and testbench

Sequencing controller for the combination-lock datapath. Consumes one-cycle debounced key pulses from the key debounce stage. Runs the code-entry state machine with inactivity timeout, an open-hold timer, a failure counter and a lockout timer, and drives the four status LEDs. An optional mode lets the user reprogram the code while the lock is open.

---
 rtl/lock_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_lock_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/lock_ctrl.sv
// lock_ctrl: combination-lock sequencer (code entry, inactivity timeout, open/fail/lockout holds, LEDs).
// Define LOCK_PROG_EN to allow reprogramming the code from OPEN through the PROG state.
module lock_ctrl #(
    parameter int unsigned           CODE_LEN     = 4,
    parameter logic [2*CODE_LEN-1:0] DEFAULT_CODE = 8'b00_01_10_11,
    parameter int unsigned           TIMEOUT      = 50_000_000,
    parameter int unsigned           OPEN_CYCLES  = 150_000_000,
    parameter int unsigned           FAIL_CYCLES  = 25_000_000,
    parameter int unsigned           MAX_FAIL     = 3,
    parameter int unsigned           LOCK_CYCLES  = 500_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] key_in,
    output logic [3:0] led,
    output logic       unlocked
);
    localparam int unsigned MAX_AB   = (TIMEOUT > OPEN_CYCLES) ? TIMEOUT : OPEN_CYCLES;
    localparam int unsigned MAX_CD   = (FAIL_CYCLES > LOCK_CYCLES) ? FAIL_CYCLES : LOCK_CYCLES;
    localparam int unsigned MAX_HOLD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned TW       = $clog2(MAX_HOLD) + 1;
    localparam int unsigned IW       = (CODE_LEN > 2) ? $clog2(CODE_LEN) : 1;
    localparam int unsigned FW       = $clog2(MAX_FAIL + 1);

    // Timers are loaded with N-1 so a state loaded at edge n is left at edge n+N.
    localparam logic [TW-1:0] T_ENTRY  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_OPEN   = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] T_FAIL   = TW'(FAIL_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCK   = TW'(LOCK_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(CODE_LEN - 1);
    localparam logic [FW-1:0] FAIL_LIM = FW'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_OPEN, S_FAIL, S_LOCKOUT
`ifdef LOCK_PROG_EN
        , S_PROG
`endif
    } state_t;

    state_t                r_state;
    logic [TW-1:0]         r_timer;
    logic [IW-1:0]         r_idx;
    logic [FW-1:0]         r_fail_cnt;
    logic                  r_err;
    logic [3:0]            r_led;
    logic                  r_unlocked;
    logic [2*CODE_LEN-1:0] w_code;
    logic                  w_press;
    logic [1:0]            w_key;
    logic [1:0]            w_digit;
    logic                  w_miss;
    logic [FW-1:0]         w_fail_nxt;

`ifdef LOCK_PROG_EN
    logic [2*CODE_LEN-1:0]     r_code;
    logic [2*(CODE_LEN-1)-1:0] r_shadow;
    assign w_code = r_code;
`else
    assign w_code = DEFAULT_CODE;
`endif

    assign w_press    = $onehot(key_in);
    assign w_miss     = r_err | (w_key != w_digit);
    assign w_fail_nxt = r_fail_cnt + FW'(1);
    assign led        = r_led;
    assign unlocked   = r_unlocked;

    always_comb begin
        w_key = 2'd0;
        case (key_in)
            4'b0010: w_key = 2'd1;
            4'b0100: w_key = 2'd2;
            4'b1000: w_key = 2'd3;
            default: w_key = 2'd0;
        endcase
    end

    always_comb begin
        w_digit = w_code[2*CODE_LEN-1 -: 2];
        for (int unsigned i = 0; i < CODE_LEN; i++)
            if (r_idx == IW'(i)) w_digit = w_code[2*(CODE_LEN-1-i) +: 2];
    end

    function automatic logic [3:0] led_of(input state_t s);
        case (s)
            S_OPEN:    led_of = 4'b0001;
            S_ENTRY:   led_of = 4'b0010;
`ifdef LOCK_PROG_EN
            S_PROG:    led_of = 4'b0010;
`endif
            S_FAIL:    led_of = 4'b0100;
            S_LOCKOUT: led_of = 4'b1000;
            default:   led_of = 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_idx      <= '0;
            r_fail_cnt <= '0;
            r_err      <= 1'b0;
            r_led      <= '0;
            r_unlocked <= 1'b0;
`ifdef LOCK_PROG_EN
            r_code     <= DEFAULT_CODE;
            r_shadow   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (w_press) begin
                    r_state <= S_ENTRY;
                    r_led   <= led_of(S_ENTRY);
                    r_err   <= (w_key != w_digit);
                    r_idx   <= IW'(1);
                    r_timer <= T_ENTRY;
                end
                S_ENTRY: if (w_press) begin
                    if (r_idx == LAST_IDX) begin
                        r_idx <= '0;
                        if (!w_miss) begin
                            r_state    <= S_OPEN;
                            r_led      <= led_of(S_OPEN);
                            r_unlocked <= 1'b1;
                            r_fail_cnt <= '0;
                            r_timer    <= T_OPEN;
                        end else if (w_fail_nxt == FAIL_LIM) begin
                            r_state    <= S_LOCKOUT;
                            r_led      <= led_of(S_LOCKOUT);
                            r_fail_cnt <= w_fail_nxt;
                            r_timer    <= T_LOCK;
                        end else begin
                            r_state    <= S_FAIL;
                            r_led      <= led_of(S_FAIL);
                            r_fail_cnt <= w_fail_nxt;
                            r_timer    <= T_FAIL;
                        end
                    end else begin
                        r_idx   <= r_idx + IW'(1);
                        r_err   <= w_miss;
                        r_timer <= T_ENTRY;
                    end
                end else if (r_timer == '0) begin
                    r_state <= S_IDLE;
                    r_led   <= led_of(S_IDLE);
                    r_idx   <= '0;
                end else begin
                    r_timer <= r_timer - TW'(1);
                end
                S_OPEN:
`ifdef LOCK_PROG_EN
                if (key_in[0] && key_in[3]) begin
                    r_state    <= S_PROG;
                    r_led      <= led_of(S_PROG);
                    r_unlocked <= 1'b0;
                    r_idx      <= '0;
                    r_timer    <= T_ENTRY;
                end else
`endif
                if (r_timer == '0) begin
                    r_state    <= S_IDLE;
                    r_led      <= led_of(S_IDLE);
                    r_unlocked <= 1'b0;
                end else begin
                    r_timer <= r_timer - TW'(1);
                end
                S_FAIL: if (r_timer == '0) begin
                    r_state <= S_IDLE;
                    r_led   <= led_of(S_IDLE);
                end else begin
                    r_timer <= r_timer - TW'(1);
                end
                S_LOCKOUT: if (r_timer == '0) begin
                    r_state    <= S_IDLE;
                    r_led      <= led_of(S_IDLE);
                    r_fail_cnt <= '0;
                end else begin
                    r_timer <= r_timer - TW'(1);
                end
`ifdef LOCK_PROG_EN
                // Shadow holds all but the last digit; the last press commits directly.
                S_PROG: if (w_press) begin
                    if (r_idx == LAST_IDX) begin
                        r_code  <= {r_shadow, w_key};
                        r_state <= S_IDLE;
                        r_led   <= led_of(S_IDLE);
                        r_idx   <= '0;
                    end else begin
                        for (int unsigned i = 0; i < CODE_LEN - 1; i++)
                            if (r_idx == IW'(i)) r_shadow[2*(CODE_LEN-2-i) +: 2] <= w_key;
                        r_idx   <= r_idx + IW'(1);
                        r_timer <= T_ENTRY;
                    end
                end else if (r_timer == '0) begin
                    r_state <= S_IDLE;
                    r_led   <= led_of(S_IDLE);
                    r_idx   <= '0;
                end else begin
                    r_timer <= r_timer - TW'(1);
                end
`endif
                default: begin
                    r_state    <= S_IDLE;
                    r_led      <= '0;
                    r_unlocked <= 1'b0;
                    r_idx      <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lock_ctrl.sv
// tb_lock_ctrl: table-driven scoreboard bench for lock_ctrl with short hold times.
// Each record pulses its key on the first cycle and expects its led value after every one of its cycles.
module tb_lock_ctrl;
    localparam logic [3:0] K0 = 4'b0001, K1 = 4'b0010, K2 = 4'b0100, K3 = 4'b1000;
    localparam logic [3:0] L_IDLE = 4'b0000, L_OPEN = 4'b0001, L_ENTRY = 4'b0010;
    localparam logic [3:0] L_FAIL = 4'b0100, L_LOCK = 4'b1000;

    typedef struct {
        logic [3:0]  key;
        int unsigned cycles;
        logic [3:0]  led;
    } vec_t;

    typedef struct {
        logic [3:0]  led;
        logic        unlocked;
        int unsigned step;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] key_in;
    logic [3:0] led;
    logic       unlocked;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    vec_t        tbl[$];
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    lock_ctrl #(
        .CODE_LEN    (4),
        .DEFAULT_CODE(8'b00_01_10_11),
        .TIMEOUT     (20),
        .OPEN_CYCLES (10),
        .FAIL_CYCLES (5),
        .MAX_FAIL    (3),
        .LOCK_CYCLES (30)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .key_in  (key_in),
        .led     (led),
        .unlocked(unlocked)
    );

    function automatic void add(input logic [3:0] k, input int unsigned c, input logic [3:0] l);
        vec_t v;
        v.key = k; v.cycles = c; v.led = l;
        tbl.push_back(v);
    endfunction

    function automatic void digits3(input logic [3:0] a, input logic [3:0] b,
                                    input logic [3:0] c, input int unsigned sp);
        add(a, sp, L_ENTRY);
        add(b, sp, L_ENTRY);
        add(c, sp, L_ENTRY);
    endfunction

    task automatic check(input string name, input logic [3:0] exp_led, input logic exp_unl);
        n_tests++;
        if (led !== exp_led || unlocked !== exp_unl) begin
            n_fail++;
            $display("FAIL %s t=%0t led=%b unlocked=%b expected led=%b unlocked=%b",
                     name, $time, led, unlocked, exp_led, exp_unl);
        end
    endtask

    task automatic run_step(input vec_t v, input int unsigned id);
        exp_t e;
        for (int unsigned c = 0; c < v.cycles; c++) begin
            key_in     = (c == 0) ? v.key : 4'b0000;
            e.led      = v.led;
            e.unlocked = v.led[0];
            e.step     = id;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("step%0d_cyc%0d", e.step, c), e.led, e.unlocked);
        end
    endtask

    task automatic do_step(input logic [3:0] k, input int unsigned c, input logic [3:0] l);
        vec_t v;
        v.key = k; v.cycles = c; v.led = l;
        run_step(v, 1000);
    endtask

    task automatic hand_entry(input logic [3:0] d3, input logic [3:0] last_led, input int unsigned n);
        do_step(K0, 3, L_ENTRY);
        do_step(K1, 3, L_ENTRY);
        do_step(K2, 3, L_ENTRY);
        do_step(d3, n, last_led);
        do_step(4'b0000, 2, L_IDLE);
    endtask

    initial begin
        rstn   = 1'b0;
        key_in = 4'b0000;

        // correct code, 5-cycle spacing
        digits3(K0, K1, K2, 5); add(K3, 10, L_OPEN); add(4'b0000, 3, L_IDLE);
        // wrong last digit: fail 1, keys in FAIL ignored
        digits3(K0, K1, K2, 5); add(K2, 2, L_FAIL); add(K0, 3, L_FAIL); add(4'b0000, 2, L_IDLE);
        // wrong first digit stays sticky: fail 2
        digits3(K3, K1, K2, 4); add(K3, 5, L_FAIL); add(4'b0000, 2, L_IDLE);
        // third failure locks out; presses during lockout ignored
        digits3(K0, K1, K2, 3); add(K2, 10, L_LOCK); add(K0, 10, L_LOCK); add(K3, 10, L_LOCK);
        add(4'b0000, 2, L_IDLE);
        digits3(K0, K1, K2, 3); add(K3, 10, L_OPEN); add(4'b0000, 2, L_IDLE);
        // fail 1, then a timeout exactly 20 cycles after the last press
        digits3(K0, K0, K2, 3); add(K3, 5, L_FAIL); add(4'b0000, 2, L_IDLE);
        add(K0, 5, L_ENTRY); add(K1, 20, L_ENTRY); add(4'b0000, 2, L_IDLE);
        // timeout left fail_cnt at 1: next failure is FAIL, the one after is LOCKOUT
        digits3(K0, K1, K2, 3); add(K2, 5, L_FAIL); add(4'b0000, 2, L_IDLE);
        digits3(K1, K1, K2, 3); add(K3, 30, L_LOCK); add(4'b0000, 2, L_IDLE);
        // press on the expiry cycle continues the entry; keys in OPEN ignored
        add(K0, 5, L_ENTRY); add(K1, 20, L_ENTRY); add(K2, 5, L_ENTRY);
        add(K3, 4, L_OPEN); add(K0, 6, L_OPEN); add(4'b0000, 2, L_IDLE);
        // multi-key cycles are not presses, in IDLE and ENTRY
        add(4'b0011, 3, L_IDLE); add(K0, 5, L_ENTRY); add(4'b0011, 5, L_ENTRY);
        add(K1, 5, L_ENTRY); add(4'b1111, 3, L_ENTRY); add(K2, 5, L_ENTRY); add(K3, 4, L_OPEN);
`ifdef LOCK_PROG_EN
        add(K1, 6, L_OPEN); add(4'b0000, 2, L_IDLE);
        // PROG timeout keeps the code
        digits3(K0, K1, K2, 3); add(K3, 3, L_OPEN); add(4'b1001, 3, L_ENTRY);
        add(K1, 20, L_ENTRY); add(4'b0000, 2, L_IDLE);
        // old code still opens; reprogram to 3,3,0,0
        digits3(K0, K1, K2, 3); add(K3, 3, L_OPEN); add(4'b1101, 3, L_ENTRY);
        add(K3, 3, L_ENTRY); add(K3, 3, L_ENTRY); add(K0, 3, L_ENTRY); add(K0, 2, L_IDLE);
        digits3(K0, K1, K2, 3); add(K3, 5, L_FAIL); add(4'b0000, 2, L_IDLE);
        digits3(K3, K3, K0, 3); add(K0, 10, L_OPEN); add(4'b0000, 2, L_IDLE);
`else
        add(4'b1001, 6, L_OPEN); add(4'b0000, 2, L_IDLE);
`endif

        @(posedge clk);
        #1;
        check("reset_state", 4'b0000, 1'b0);
        #3 rstn = 1'b1;

        for (int unsigned i = 0; i < tbl.size(); i++) run_step(tbl[i], i);
        key_in = 4'b0000;

        // two failures, partial entry, then asynchronous reset clears everything
        hand_entry(K2, L_FAIL, 5);
        hand_entry(K2, L_FAIL, 5);
        do_step(K0, 3, L_ENTRY);
        do_step(K1, 3, L_ENTRY);
        #2 rstn = 1'b0;
        #1 check("async_reset", 4'b0000, 1'b0);
        @(posedge clk);
        #1 check("reset_hold", 4'b0000, 1'b0);
        #3 rstn = 1'b1;
        hand_entry(K2, L_FAIL, 5);
        hand_entry(K3, L_OPEN, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
